// File: rtl/alu_mdu.sv
// Execute-stage unit: combinational MIPS ALU plus an iterative multiply/divide
// unit that owns the architectural HI/LO registers.
module alu_mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUControlE,
    output logic [WIDTH-1:0] ALUOutE,
    output logic             OverflowE,
    input  logic             MDStartE,
    input  logic [2:0]       MDOpE,
    output logic             MDBusyE,
    output logic             MDDoneE,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] CNT_LAST = {SHW{1'b1}};

    localparam logic [3:0] OP_ADDU = 4'd0,  OP_ADD  = 4'd1,  OP_SUBU = 4'd2,  OP_SUB  = 4'd3;
    localparam logic [3:0] OP_SLTU = 4'd4,  OP_SLT  = 4'd5,  OP_SLL  = 4'd6,  OP_SLLV = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8,  OP_SRLV = 4'd9,  OP_SRA  = 4'd10, OP_SRAV = 4'd11;
    localparam logic [3:0] OP_AND  = 4'd12, OP_OR   = 4'd13, OP_XOR  = 4'd14, OP_NOR  = 4'd15;

    localparam logic [2:0] MD_MULT = 3'd0, MD_MULTU = 3'd1, MD_DIV = 3'd2, MD_DIVU = 3'd3;
    localparam logic [2:0] MD_MTHI = 3'd4, MD_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } md_state_e;

    logic [SHW-1:0]   shamt_s;
    logic [WIDTH-1:0] sum_s;
    logic [WIDTH-1:0] diff_s;

    assign shamt_s = A[SHW-1:0];
    assign sum_s   = A + B;
    assign diff_s  = A - B;

    // ALU result and signed-overflow flag
    always_comb begin
        ALUOutE   = {WIDTH{1'b0}};
        OverflowE = 1'b0;
        case (ALUControlE)
            OP_ADDU: ALUOutE = sum_s;
            OP_ADD: begin
                ALUOutE   = sum_s;
                OverflowE = (A[WIDTH-1] == B[WIDTH-1]) && (sum_s[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUBU: ALUOutE = diff_s;
            OP_SUB: begin
                ALUOutE   = diff_s;
                OverflowE = (A[WIDTH-1] != B[WIDTH-1]) && (diff_s[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SLTU:          ALUOutE = {{(WIDTH-1){1'b0}}, (A < B)};
            OP_SLT:           ALUOutE = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLL, OP_SLLV:  ALUOutE = B << shamt_s;
            OP_SRL, OP_SRLV:  ALUOutE = B >> shamt_s;
            OP_SRA, OP_SRAV:  ALUOutE = $unsigned($signed(B) >>> shamt_s);
            OP_AND:           ALUOutE = A & B;
            OP_OR:            ALUOutE = A | B;
            OP_XOR:           ALUOutE = A ^ B;
            OP_NOR:           ALUOutE = ~(A | B);
            default:          ALUOutE = {WIDTH{1'b0}};
        endcase
    end

    md_state_e          state_q, state_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic               neg_q, neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic               div0_q, div0_d;
    logic               is_div_q, is_div_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               sgn_op_s;
    logic [WIDTH-1:0]   mag_a_s;
    logic [WIDTH-1:0]   mag_b_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [2*WIDTH-1:0] mul_step_s;
    logic [WIDTH:0]     div_trial_s;
    logic [WIDTH-1:0]   div_rem_s;
    logic               div_ge_s;
    logic [2*WIDTH-1:0] div_step_s;
    logic [2*WIDTH-1:0] mul_res_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;

    assign sgn_op_s = ~MDOpE[0];
    assign mag_a_s  = (sgn_op_s && A[WIDTH-1]) ? ({WIDTH{1'b0}} - A) : A;
    assign mag_b_s  = (sgn_op_s && B[WIDTH-1]) ? ({WIDTH{1'b0}} - B) : B;

    // prod_q holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
    assign mul_sum_s  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
    assign mul_step_s = {mul_sum_s, prod_q[WIDTH-1:1]};

    assign div_trial_s = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
    assign div_ge_s    = (div_trial_s >= {1'b0, opb_q});
    assign div_rem_s   = div_trial_s[WIDTH-1:0] - opb_q;
    assign div_step_s  = div_ge_s ? {div_rem_s, prod_q[WIDTH-2:0], 1'b1}
                                  : {div_trial_s[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};

    assign mul_res_s = neg_q ? ({(2*WIDTH){1'b0}} - prod_q) : prod_q;
    assign quo_s     = prod_q[WIDTH-1:0];
    assign rem_s     = prod_q[2*WIDTH-1:WIDTH];

    // MDU next-state, iteration datapath and HI/LO update
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prod_d    = prod_q;
        opb_d     = opb_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        div0_d    = div0_q;
        is_div_d  = is_div_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (MDStartE) begin
                    case (MDOpE)
                        MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                            state_d   = MDOpE[1] ? S_DIV : S_MUL;
                            cnt_d     = {SHW{1'b0}};
                            prod_d    = {{WIDTH{1'b0}}, mag_a_s};
                            opb_d     = mag_b_s;
                            neg_d     = sgn_op_s && (A[WIDTH-1] ^ B[WIDTH-1]);
                            rem_neg_d = sgn_op_s && A[WIDTH-1];
                            div0_d    = (B == {WIDTH{1'b0}});
                            is_div_d  = MDOpE[1];
                            busy_d    = 1'b1;
                        end
                        MD_MTHI: hi_d    = A;
                        MD_MTLO: lo_d    = A;
                        default: state_d = S_IDLE;
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL, S_DIV: begin
                prod_d = (state_q == S_DIV) ? div_step_s : mul_step_s;
                cnt_d  = cnt_q + SHW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_FIX;
                end else begin
                    state_d = state_q;
                end
            end
            S_FIX: begin
                if (is_div_q) begin
                    lo_d = div0_q ? {WIDTH{1'b1}} : (neg_q ? ({WIDTH{1'b0}} - quo_s) : quo_s);
                    hi_d = rem_neg_q ? ({WIDTH{1'b0}} - rem_s) : rem_s;
                end else begin
                    hi_d = mul_res_s[2*WIDTH-1:WIDTH];
                    lo_d = mul_res_s[WIDTH-1:0];
                end
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // MDU state register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= {SHW{1'b0}};
            prod_q    <= {(2*WIDTH){1'b0}};
            opb_q     <= {WIDTH{1'b0}};
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            div0_q    <= 1'b0;
            is_div_q  <= 1'b0;
            hi_q      <= {WIDTH{1'b0}};
            lo_q      <= {WIDTH{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prod_q    <= prod_d;
            opb_q     <= opb_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            div0_q    <= div0_d;
            is_div_q  <= is_div_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign MDBusyE = busy_q;
    assign MDDoneE = done_q;
    assign HI      = hi_q;
    assign LO      = lo_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: ALU vectors plus a scoreboard of HI/LO
// results pushed at MDU start and popped on the MDDoneE pulse.
module tb_alu_mdu;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic [3:0]    ALUControlE;
    logic [W-1:0]  ALUOutE;
    logic          OverflowE;
    logic          MDStartE;
    logic [2:0]    MDOpE;
    logic          MDBusyE;
    logic          MDDoneE;
    logic [W-1:0]  HI;
    logic [W-1:0]  LO;

    int            n_vec;
    int            n_err;
    logic [63:0]   exp_q[$];

    always #5 clk = ~clk;

    alu_mdu #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .ALUControlE(ALUControlE),
        .ALUOutE(ALUOutE), .OverflowE(OverflowE), .MDStartE(MDStartE), .MDOpE(MDOpE),
        .MDBusyE(MDBusyE), .MDDoneE(MDDoneE), .HI(HI), .LO(LO)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference {HI,LO} for mult/div ops, built from native 64-bit arithmetic
    function automatic logic [63:0] md_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0: r = sa * sb;
            3'd1: r = {32'h0, a} * {32'h0, b};
            3'd2: begin
                if (b == 32'h0)                                r = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
                else                                            r = {32'(sa % sb), 32'(sa / sb)};
            end
            3'd3: begin
                if (b == 32'h0) r = {a, 32'hFFFF_FFFF};
                else            r = {a % b, a / b};
            end
            default: r = 64'h0;
        endcase
        return r;
    endfunction

    task automatic alu_vec(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] y, input logic ov);
        ALUControlE = op;
        A = a;
        B = b;
        #1;
        check_val(tag, 64'(ALUOutE), 64'(y));
        check_val({tag, "_ov"}, 64'(OverflowE), 64'(ov));
    endtask

    // Start an MDU op, optionally inject an ignored MULT start, then compare on MDDoneE
    task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int inject_at);
        int          busy_cycles;
        bit          seen;
        bit          changed;
        logic [31:0] hi0;
        logic [31:0] lo0;
        logic [63:0] exp;
        exp_q.push_back(md_model(op, a, b));
        MDOpE    = op;
        A        = a;
        B        = b;
        MDStartE = 1'b1;
        hi0      = HI;
        lo0      = LO;
        @(posedge clk);
        #1;
        MDStartE    = 1'b0;
        busy_cycles = 0;
        seen        = 1'b0;
        changed     = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (MDDoneE) begin
                seen = 1'b1;
            end else if (MDBusyE) begin
                busy_cycles++;
                if (HI !== hi0 || LO !== lo0) changed = 1'b1;
            end
            if (i == inject_at) begin
                MDOpE    = 3'd0;
                A        = 32'd3;
                B        = 32'd5;
                MDStartE = 1'b1;
            end else begin
                MDStartE = 1'b0;
            end
        end
        check_val({tag, "_done"}, 64'(seen), 64'd1);
        check_val({tag, "_busy"}, 64'(busy_cycles), 64'(W + 1));
        check_val({tag, "_hold"}, 64'(changed), 64'd0);
        exp = exp_q.pop_front();
        check_val({tag, "_hi"}, 64'(HI), 64'(exp[63:32]));
        check_val({tag, "_lo"}, 64'(LO), 64'(exp[31:0]));
    endtask

    initial begin
        bit stray_done;
        n_vec       = 0;
        n_err       = 0;
        reset       = 1'b1;
        A           = 32'h0;
        B           = 32'h0;
        ALUControlE = 4'd0;
        MDStartE    = 1'b0;
        MDOpE       = 3'd6;
        repeat (3) @(negedge clk);
        check_val("rst_busy", 64'(MDBusyE), 64'd0);
        check_val("rst_done", 64'(MDDoneE), 64'd0);
        check_val("rst_hi",   64'(HI), 64'd0);
        check_val("rst_lo",   64'(LO), 64'd0);
        reset = 1'b0;

        alu_vec("add_ovf",  4'd1,  32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b1);
        alu_vec("addu",     4'd0,  32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b0);
        alu_vec("add_neg",  4'd1,  32'h8000_0000, 32'h8000_0000, 32'h0,         1'b1);
        alu_vec("add_ok",   4'd1,  32'hFFFF_FFFF, 32'h2,         32'h1,         1'b0);
        alu_vec("sub_ovf",  4'd3,  32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 1'b1);
        alu_vec("sub_ovf2", 4'd3,  32'h0,         32'h8000_0000, 32'h8000_0000, 1'b1);
        alu_vec("subu",     4'd2,  32'h5,         32'h7,         32'hFFFF_FFFE, 1'b0);
        alu_vec("slt",      4'd5,  32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0);
        alu_vec("sltu",     4'd4,  32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0);
        alu_vec("sll",      4'd6,  32'h4,         32'h1,         32'h10,        1'b0);
        alu_vec("sllv",     4'd7,  32'h24,        32'h3,         32'h30,        1'b0);
        alu_vec("srl",      4'd8,  32'h4,         32'h8000_0000, 32'h0800_0000, 1'b0);
        alu_vec("srlv",     4'd9,  32'h1,         32'h3,         32'h1,         1'b0);
        alu_vec("sra",      4'd10, 32'h4,         32'h8000_0000, 32'hF800_0000, 1'b0);
        alu_vec("srav",     4'd11, 32'h1F,        32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        alu_vec("sra0",     4'd10, 32'h20,        32'h8000_0000, 32'h8000_0000, 1'b0);
        alu_vec("and",      4'd12, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0);
        alu_vec("or",       4'd13, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0);
        alu_vec("xor",      4'd14, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0);
        alu_vec("nor",      4'd15, 32'h0,         32'h0,         32'hFFFF_FFFF, 1'b0);

        // MTHI / MTLO act at the sampling edge and never raise busy or done
        @(negedge clk);
        MDOpE = 3'd4; A = 32'h1234; MDStartE = 1'b1;
        @(posedge clk);
        #1;
        MDStartE = 1'b0;
        @(negedge clk);
        check_val("mthi_hi",   64'(HI), 64'h1234);
        check_val("mthi_busy", 64'(MDBusyE), 64'd0);
        check_val("mthi_done", 64'(MDDoneE), 64'd0);
        MDOpE = 3'd5; A = 32'hABCD; MDStartE = 1'b1;
        @(posedge clk);
        #1;
        MDStartE = 1'b0;
        @(negedge clk);
        check_val("mtlo_lo", 64'(LO), 64'hABCD);
        check_val("mtlo_hi", 64'(HI), 64'h1234);

        run_md("mult", 3'd0, 32'hFFFF_FFFD, 32'h7, -1);
        @(negedge clk);
        check_val("mult_pulse", 64'(MDDoneE), 64'd0);
        check_val("mult_keep",  64'(LO), 64'hFFFF_FFEB);

        run_md("multu",  3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        run_md("div_b2b", 3'd2, 32'hFFFF_FFF9, 32'h2,        -1);
        run_md("divu_z", 3'd3, 32'h7,         32'h0,         -1);
        run_md("div_min", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        run_md("div_z",  3'd2, 32'hFFFF_FFFB, 32'h0,         -1);
        run_md("div_inj", 3'd2, 32'd100,      32'hFFFF_FFF9, 4);
        for (int k = 0; k < 4; k++) begin
            logic [2:0]  rop;
            logic [31:0] ra;
            logic [31:0] rb;
            rop = 3'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (k == 1) ? 32'($urandom_range(1, 20)) : $urandom;
            run_md("rnd", rop, ra, rb, -1);
        end

        // Reset mid-DIVU aborts the op with no result and no done pulse
        @(negedge clk);
        MDOpE = 3'd3; A = 32'd1000; B = 32'd3; MDStartE = 1'b1;
        @(posedge clk);
        #1;
        MDStartE = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_val("abort_busy", 64'(MDBusyE), 64'd0);
        check_val("abort_hi",   64'(HI), 64'd0);
        check_val("abort_lo",   64'(LO), 64'd0);
        check_val("abort_done", 64'(MDDoneE), 64'd0);
        stray_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (MDDoneE) stray_done = 1'b1;
        end
        check_val("abort_nopulse", 64'(stray_done), 64'd0);
        run_md("multu_post", 3'd1, 32'h0001_0003, 32'h0002_0005, -1);

        check_val("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
- Parametrised-width execute-stage unit for the pipelined MIPS core.
- Contains a combinational ALU datapath using the same 16 op codes as the current ALU.
- Adds signed-overflow detection for ADD/SUB.
- Adds an iterative multiply/divide unit (MDU) with architectural HI/LO registers, so the core can support MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO. The hazard unit stalls the core on MDBusyE.

Parameters:
- WIDTH, 32, datapath width in bits; must be a power of two, >= 8.
- SHW, $clog2(WIDTH), localparam; number of shift-amount bits taken from A.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- A  in  WIDTH  operand A (rs, or shamt for SLL/SRL/SRA).
- B  in  WIDTH  operand B (rt or immediate).
- ALUControlE  in  4  ALU op code: ADDU 0, ADD 1, SUBU 2, SUB 3, SLTU 4, SLT 5, SLL 6, SLLV 7, SRL 8, SRLV 9, SRA 10, SRAV 11, AND 12, OR 13, XOR 14, NOR 15.
- ALUOutE  out  WIDTH  combinational ALU result.
- OverflowE  out  1  combinational; 1 only for ADD/SUB on signed overflow.
- MDStartE  in  1  request the MDU op given on MDOpE.
- MDOpE  in  3  MDU op: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are no-op.
- MDBusyE  out  1  MDU iterating; registered.
- MDDoneE  out  1  one-cycle pulse when HI/LO receive a mult/div result; registered.
- HI  out  WIDTH  HI register.
- LO  out  WIDTH  LO register.

Behaviour:
- Reset: HI=0, LO=0, MDBusyE=0, MDDoneE=0, FSM in IDLE, iteration counter 0. Reset takes priority over everything, including an operation in progress; that operation is aborted and produces no result.
- ALU path (purely combinational, zero latency, independent of the MDU state):
  - Shifts use A[SHW-1:0]. SRA/SRAV are arithmetic.
  - SLT is signed; SLTU is unsigned. Both return 0 or 1 zero-extended.
  - ADD/SUB results are the wrapped sum/difference.
  - OverflowE = (ADD: A and B have the same sign and the result sign differs) or (SUB: A and B have different signs and the result sign differs from A). OverflowE=0 for all other ops.
- MDU FSM states: IDLE, MUL, DIV, FIX.
  - IDLE, MDStartE=1, op MULT/MULTU: latch operand magnitudes (signed ops use absolute values) and latch the result sign; go to MUL; MDBusyE=1 from the next cycle.
  - IDLE, MDStartE=1, op DIV/DIVU: same latching; go to DIV.
  - IDLE, MDStartE=1, op MTHI/MTLO: HI<=A or LO<=A at that edge; stay IDLE; MDBusyE stays 0; no MDDoneE.
  - MUL: radix-2 shift-add, one bit per cycle, WIDTH cycles; then FIX.
  - DIV: restoring division, one quotient bit per cycle, WIDTH cycles; then FIX.
  - FIX: apply signs and write HI/LO. Next cycle: IDLE, MDBusyE=0, MDDoneE=1 for exactly one cycle.
- Latency: if the start is sampled at edge E0, MDBusyE is high for WIDTH+1 cycles. HI/LO are valid, and MDDoneE=1, after edge E0+WIDTH+1.
- MDStartE while MDBusyE=1 is ignored: no queueing, no effect on the current op. The pipeline must stall instead.
- A start in the same cycle as the MDDoneE pulse is accepted, because the FSM is already IDLE.
- Multiply result: {HI,LO} = full 2*WIDTH-bit product. For MULT the product is negated if the operand signs differ.
- Divide result: LO = quotient, HI = remainder. For DIV:
  - the quotient is negated if the signs differ;
  - the remainder takes the sign of the dividend (A).
- DIV with A = most-negative value and B = -1: LO = most-negative value, HI = 0.
- Divide by zero (B=0): LO = all-ones, HI = A. This holds for both DIV and DIVU; no exception is raised.
- HI/LO are never modified while MDBusyE=1 except by reset.

Test Plan:
- ALU, WIDTH=32: ADD with A=0x7FFFFFFF, B=1 -> ALUOutE=0x80000000, OverflowE=1. ADDU with the same operands -> OverflowE=0. SRA with A=4, B=0x80000000 -> 0xF8000000.
- MULT with A=-3 (0xFFFFFFFD), B=7, start sampled at E0 -> MDBusyE=1 for 33 cycles; after E0+33, HI=0xFFFFFFFF, LO=0xFFFFFFEB, MDDoneE=1 for exactly one cycle.
- MULTU with A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV cases:
  - A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU with A=7, B=0 -> LO=0xFFFFFFFF, HI=7.
  - DIV with A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI with A=0x1234 while idle -> HI=0x1234 next cycle, MDBusyE stays 0. A MULT start 5 cycles into a DIV -> ignored; the DIV result is unchanged.
- reset asserted 10 cycles into a DIVU -> next cycle MDBusyE=0, HI=LO=0, no MDDoneE pulse. A new MULTU started afterwards completes correctly.
